// File: rtl/agex_mul_seq.sv
// Iterative shift-add multiply sequencer for the AGEX stage; stalls the front end until the product is ready.
// Optional macro AGEX_MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for an unflushed start
// RUN   | one shift-add iteration per cycle
// FIXUP | apply sign to the accumulated magnitude product
// DONE  | present product for one cycle, count the op
module agex_mul_seq #(
    parameter int DBITS = 32,
    parameter int CNT_W = $clog2(DBITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [DBITS-1:0]     op_a_i,
    input  logic [DBITS-1:0]     op_b_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*DBITS-1:0]   product_o,
    output logic [31:0]          op_count_o
);

    localparam int PW = 2 * DBITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     mcand;
    logic [DBITS-1:0]  mplier;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     product_q;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       op_count;
    logic              neg;

    logic              accept;
    logic              last_iter;
    logic [DBITS-1:0]  abs_a;
    logic [DBITS-1:0]  abs_b;
    logic [DBITS-1:0]  mplier_shift;
    logic [PW-1:0]     addend;
    logic [PW-1:0]     acc_fix;

    // The most negative operand negates to itself, which read as unsigned is exactly its magnitude.
    assign abs_a        = (signed_i && op_a_i[DBITS-1]) ? (~op_a_i + DBITS'(1)) : op_a_i;
    assign abs_b        = (signed_i && op_b_i[DBITS-1]) ? (~op_b_i + DBITS'(1)) : op_b_i;
    assign mplier_shift = mplier >> 1;
    assign addend       = mplier[0] ? mcand : '0;
    assign acc_fix      = neg ? (~acc + PW'(1)) : acc;

`ifdef AGEX_MUL_EARLY_TERM_EN
    assign last_iter = (cnt == CNT_W'(1)) || (mplier_shift == '0);
`else
    assign last_iter = (cnt == CNT_W'(1));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else if (last_iter) begin
                    state_nxt = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_nxt = flush_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
            product_q <= '0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                mcand  <= {{DBITS{1'b0}}, abs_a};
                mplier <= abs_b;
                neg    <= signed_i & (op_a_i[DBITS-1] ^ op_b_i[DBITS-1]);
                acc    <= '0;
                cnt    <= CNT_W'(DBITS);
            end
            if (state == S_RUN && !flush_i) begin
                acc    <= acc + addend;
                mcand  <= mcand << 1;
                mplier <= mplier_shift;
                cnt    <= cnt - CNT_W'(1);
            end
            // A flushed op never reaches the visible product register.
            if (state == S_FIXUP && !flush_i) begin
                acc       <= acc_fix;
                product_q <= acc_fix;
            end
            if (state == S_DONE) begin
                op_count <= op_count + 32'd1;
            end
        end
    end

    assign stall_o    = ((state == S_IDLE) && start_i && !flush_i) ||
                        (state == S_RUN) || (state == S_FIXUP);
    assign busy_o     = (state != S_IDLE);
    assign done_o     = (state == S_DONE);
    assign product_o  = product_q;
    assign op_count_o = op_count;

endmodule

// File: tb/tb_agex_mul_seq.sv
// Scoreboard bench for agex_mul_seq: expected products queued at accept, compared on done_o.
// Expected latencies follow AGEX_MUL_EARLY_TERM_EN when the bench is built with it.
module tb_agex_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [63:0] product_o;
    logic [31:0] op_count_o;

    int          n_chk = 0;
    int          n_err = 0;
    int          exp_cnt = 0;
    logic [63:0] exp_q[$];

    agex_mul_seq #(.DBITS(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .product_o  (product_o),
        .op_count_o (op_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int model_lat(input logic [31:0] b, input logic s);
`ifdef AGEX_MUL_EARLY_TERM_EN
        logic [31:0] mag;
        int          hi;
        mag = (s && b[31]) ? (~b + 32'd1) : b;
        hi  = 0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) hi = i;
        end
        return hi + 3;
`else
        return 34 + 0 * int'(b[0] & s);
`endif
    endfunction

    // Product checks happen here, once per done_o pulse.
    always @(negedge clk) begin
        if (reset_n && done_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'(done_o), 64'd0);
            end else begin
                chk("product", product_o, exp_q.pop_front());
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hold);
        @(negedge clk);
        op_a_i   = a;
        op_b_i   = b;
        signed_i = s;
        start_i  = 1'b1;
        flush_i  = 1'b0;
        exp_q.push_back(model_prod(a, b, s));
        #1 chk("stall_accept", 64'(stall_o), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            start_i  = 1'b0;
            op_a_i   = $urandom;
            op_b_i   = $urandom;
            signed_i = 1'($urandom);
        end
    endtask

    // Entered in the first RUN cycle; returns in the DONE cycle.
    task automatic wait_done(input int want_lat);
        int lat;
        int st;
        lat = 1;
        st  = 1;
        while (!done_o && lat < 60) begin
            if (stall_o) st++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(want_lat));
        chk("stall_cycles", 64'(st), 64'(want_lat));
        chk("stall_in_done", 64'(stall_o), 64'd0);
        exp_cnt++;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        start_op(a, b, s, 1'b0);
        wait_done(model_lat(b, s));
        @(posedge clk);
        #1 chk("op_count", 64'(op_count_o), 64'(exp_cnt));
        chk("busy_after", 64'(busy_o), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_product", product_o, 64'd0);
        chk("rst_count", 64'(op_count_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(32'd3, 32'd5, 1'b0);
        chk("tp_unsigned", product_o, 64'h0000_0000_0000_000F);
        chk("tp_count1", 64'(op_count_o), 64'd1);
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1);
        chk("tp_signed", product_o, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("tp_minmin_s", product_o, 64'h4000_0000_0000_0000);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("tp_minmin_u", product_o, 64'h4000_0000_0000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("tp_max_u", product_o, 64'hFFFF_FFFE_0000_0001);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(32'd12345, 32'hFFFF_FF00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, 1'($urandom));
        end

        // Flush during the 10th RUN cycle.
        start_op(32'h0000_1111, 32'h8000_0001, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("flush_busy_before", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_stall", 64'(stall_o), 64'd0);
        repeat (40) @(posedge clk);
        #1 chk("flush_count", 64'(op_count_o), 64'(exp_cnt));
        run_op(32'd2, 32'd2, 1'b0);
        chk("after_flush", product_o, 64'd4);

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        start_i = 1'b1;
        flush_i = 1'b1;
        #1 chk("idle_flush_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1 chk("idle_flush_busy", 64'(busy_o), 64'd0);
        start_i = 1'b0;
        flush_i = 1'b0;

        // start_i held through a whole op: retried and accepted the cycle after DONE.
        start_op(32'd9, 32'd11, 1'b0, 1'b1);
        wait_done(model_lat(32'd11, 1'b0));
        @(posedge clk);
        #1;
        chk("hold_idle_busy", 64'(busy_o), 64'd0);
        chk("hold_idle_stall", 64'(stall_o), 64'd1);
        chk("hold_count1", 64'(op_count_o), 64'(exp_cnt));
        exp_q.push_back(model_prod(32'd9, 32'd11, 1'b0));
        @(posedge clk);
        #1;
        chk("hold_second_busy", 64'(busy_o), 64'd1);
        start_i = 1'b0;
        wait_done(model_lat(32'd11, 1'b0));
        @(posedge clk);
        #1 chk("hold_count2", 64'(op_count_o), 64'(exp_cnt));

        // Asynchronous reset in RUN cycle 5.
        start_op(32'h0000_1234, 32'hF000_0000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_stall", 64'(stall_o), 64'd0);
        chk("arst_product", product_o, 64'd0);
        chk("arst_count", 64'(op_count_o), 64'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op(32'd100, 32'd200, 1'b0);
        chk("post_rst_count", 64'(op_count_o), 64'd1);

        run_op(32'd6, 32'd2, 1'b0);
        chk("short_b2", product_o, 64'd12);
        run_op(32'd6, 32'd0, 1'b0);
        chk("short_b0", product_o, 64'd0);

        repeat (3) @(posedge clk);
        #1 chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
